oam_dma_controller: RTL and testbench
=====================================

# oam_dma_controller

Game Boy Color OAM DMA engine and bus master that sits directly upstream of the BRAM wrappers, between the CPU bus and the memory router. When idle it passes CPU accesses straight through to the memory-side bus. A CPU write to 0xFF46 makes it take the bus and copy 160 bytes from `{val,8'h00}` to OAM at 0xFE00–0xFE9F, using the same `ADDR` / `DATA` / `WE_L` / `RE_L` protocol the BRAM wrappers consume.

## Interface
Parameters:
- `P_READ_LATENCY`, default 2: cycles `O_MEM_RE_L` is held low per read; data is sampled on the last of these cycles. Legal range 1–7.

Ports:
- `I_CLK` in 1: single system clock; all state on rising edge.
- `I_RESET` in 1: asynchronous, active-high reset.
- `I_CPU_ADDR` in 16: CPU address.
- `I_CPU_DATA` in 8: CPU write data.
- `O_CPU_DATA` out 8: CPU read data.
- `I_CPU_WE_L` in 1: CPU write strobe, active low.
- `I_CPU_RE_L` in 1: CPU read strobe, active low.
- `O_MEM_ADDR` out 16: address to memory router / BRAM wrappers.
- `IO_MEM_DATA` inout 8: memory data bus, tristated when not writing.
- `O_MEM_WE_L` out 1: memory write strobe, active low.
- `O_MEM_RE_L` out 1: memory read strobe, active low.
- `O_DMA_ACTIVE` out 1: high while the engine owns the bus. The memory router routes CPU accesses to HRAM (0xFF80–0xFFFE) around this block while this is high.
- `O_DMA_DONE` out 1: one-cycle pulse when the transfer completes.

## Operation
- Register `dma_reg` (8b) holds the last value written to 0xFF46.
  - A write is taken on the first cycle of a `I_CPU_WE_L` low period, using falling-edge detect, so exactly one capture per strobe.
  - Reads of 0xFF46 always return `dma_reg`.
- Source base address:
  - `src = {dma_reg, 8'h00}`.
  - If `dma_reg >= 8'hE0`, subtract 0x2000 (echo-RAM fold). Example: 0xE1 → 0xC100.
- Destination address = 0xFE00 + `idx`, where `idx` runs 0..159 (8-bit counter).
- States:
  - IDLE: bus pass-through.
    - `O_MEM_ADDR` = `I_CPU_ADDR`; `WE_L` / `RE_L` follow the CPU strobes.
    - `IO_MEM_DATA` is driven with `I_CPU_DATA` when `I_CPU_WE_L` is low, otherwise Z.
    - `O_CPU_DATA` = `IO_MEM_DATA`, except at 0xFF46.
    - A write to 0xFF46 captures the value → START.
  - START: one cycle; `idx` = 0, latency counter cleared, `O_DMA_ACTIVE` = 1 → READ.
  - READ:
    - `O_MEM_ADDR` = `src + idx`, `RE_L` = 0.
    - Lasts `P_READ_LATENCY` cycles.
    - On the last cycle, latch `IO_MEM_DATA` into `byte_buf` → WRITE.
  - WRITE:
    - `O_MEM_ADDR` = `0xFE00 + idx`, `WE_L` = 0 for one cycle, `IO_MEM_DATA` = `byte_buf`.
    - If `idx` == 159 → IDLE and pulse `O_DMA_DONE`; otherwise `idx + 1` → READ.
- CPU behaviour while ACTIVE (START/READ/WRITE):
  - CPU reads of anything except 0xFF46 return 0xFF; CPU writes are dropped.
  - A write to 0xFF46 updates `dma_reg` and forces START on the next cycle (restart from `idx` 0 with the new source). The current byte is abandoned; no partial write is issued.
- Only one of `WE_L` / `RE_L` is low in any cycle.

## Timing
- Reset (asynchronous) values:
  - State IDLE, `dma_reg` = 0x00, `idx` = 0, `byte_buf` = 0x00.
  - `O_DMA_ACTIVE` = 0, `O_DMA_DONE` = 0.
  - While `I_RESET` is high: `O_MEM_WE_L` = 1, `O_MEM_RE_L` = 1, `IO_MEM_DATA` = Z, `O_CPU_DATA` = 0xFF.
- Reset asserted mid-transfer aborts immediately. OAM contents already written stay written.
- Cycle timing after the 0xFF46 write cycle T:
  - START at T+1.
  - First READ at T+2.
  - Per-byte cost is `P_READ_LATENCY` + 1 cycles.
  - Total with the default is 1 + 160×3 = 481 cycles.
  - `O_DMA_DONE` is high in the cycle after the final WRITE, coincident with `O_DMA_ACTIVE` falling.
- Pass-through in IDLE is combinational (zero added latency).
- `O_DMA_ACTIVE` and `O_DMA_DONE` are registered.
- A 0xFF46 write in the same cycle as the final WRITE takes priority: restart, no DONE pulse.

## Structure
- Shared package `gbc_mem_map_pkg`:
  - `ADDR_DMA_REG` = 16'hFF46, `OAM_BASE` = 16'hFE00, `OAM_LEN` = 160.
  - `HRAM_LO` = 16'hFF80, `HRAM_HI` = 16'hFFFE, `ECHO_FOLD` = 16'h2000.
  - DMA state encoding (IDLE / START / READ / WRITE).
- One sub-module, `oam_dma_bus_mux`: combinational selection between the CPU and DMA drivers of `O_MEM_*` and `IO_MEM_DATA`, and generation of `O_CPU_DATA`. The sequencer stays in the top module.

## Test plan
- Idle pass-through: CPU write 0x5A to 0xC010, then read back → `O_MEM_*` mirror the CPU; `O_CPU_DATA` = 0x5A; `O_DMA_ACTIVE` stays 0.
- Full transfer: preload 0xC000–0xC09F with `i ^ 0xA5`, write 0xC0 to 0xFF46 → 160 writes to 0xFE00+i with matching data; `O_DMA_DONE` pulses exactly 481 cycles after the write; 0xFF46 reads 0xC0.
- Blocking: during a transfer, CPU reads 0xC000 → 0xFF, and a CPU write to 0xD000 → no memory write appears.
- Echo fold and restart: write 0xE1, then write 0xC2 after 50 cycles → reads from 0xC100, then a restart at 0xFE00 sourcing 0xC200; only one DONE pulse.
- Reset mid-transfer: assert `I_RESET` at byte 80 → same-cycle `WE_L` / `RE_L` = 1, `O_DMA_ACTIVE` = 0, `dma_reg` = 0x00; bytes 0..79 remain in OAM.

Source files
------------

// File: rtl/gbc_mem_map_pkg.sv
// Shared Game Boy Color memory-map constants and the OAM DMA state encoding.
package gbc_mem_map_pkg;

  localparam logic [15:0] ADDR_DMA_REG = 16'hFF46;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam int unsigned OAM_LEN      = 160;
  localparam logic [15:0] HRAM_LO      = 16'hFF80;
  localparam logic [15:0] HRAM_HI      = 16'hFFFE;
  localparam logic [15:0] ECHO_FOLD    = 16'h2000;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StRead  = 2'd2,
    StWrite = 2'd3
  } dma_state_e;

  // Source base for a DMA page; pages E0..FF alias work RAM (echo region).
  function automatic logic [15:0] dma_src_base(input logic [7:0] page);
    logic [15:0] base;
    base = {page, 8'h00};
    if (page >= 8'hE0) begin
      base = base - ECHO_FOLD;
    end
    return base;
  endfunction

endpackage

// File: rtl/oam_dma_bus_mux.sv
// Selects CPU or DMA as driver of the memory-side bus and forms CPU read data.
module oam_dma_bus_mux
  import gbc_mem_map_pkg::*;
(
  input  logic        i_reset,
  input  logic        i_busy,
  input  logic [15:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_data,
  input  logic        i_cpu_we_l,
  input  logic        i_cpu_re_l,
  input  logic [15:0] i_dma_addr,
  input  logic [7:0]  i_dma_data,
  input  logic        i_dma_we_l,
  input  logic        i_dma_re_l,
  input  logic [7:0]  i_dma_reg,
  input  logic [7:0]  i_mem_data,
  output logic [15:0] o_mem_addr,
  output logic [7:0]  o_mem_data,
  output logic        o_mem_oe,
  output logic        o_mem_we_l,
  output logic        o_mem_re_l,
  output logic [7:0]  o_cpu_data
);

  logic w_dma_reg_hit;
  assign w_dma_reg_hit = (i_cpu_addr == ADDR_DMA_REG);

  // Bus ownership: reset forces everything inactive, DMA owns it while busy.
  always_comb begin
    o_mem_addr = i_cpu_addr;
    o_mem_data = i_cpu_data;
    o_mem_oe   = 1'b0;
    o_mem_we_l = 1'b1;
    o_mem_re_l = 1'b1;
    o_cpu_data = 8'hFF;
    if (i_reset) begin
      o_cpu_data = 8'hFF;
    end else if (i_busy) begin
      o_mem_addr = i_dma_addr;
      o_mem_data = i_dma_data;
      o_mem_oe   = ~i_dma_we_l;
      o_mem_we_l = i_dma_we_l;
      o_mem_re_l = i_dma_re_l;
      o_cpu_data = w_dma_reg_hit ? i_dma_reg : 8'hFF;
    end else begin
      o_mem_oe   = ~i_cpu_we_l;
      o_mem_we_l = i_cpu_we_l;
      // A write strobe wins so both strobes are never low together.
      o_mem_re_l = i_cpu_re_l | ~i_cpu_we_l;
      o_cpu_data = w_dma_reg_hit ? i_dma_reg : i_mem_data;
    end
  end

endmodule

// File: rtl/oam_dma_controller.sv
// OAM DMA engine: CPU bus pass-through when idle, 160-byte copy to OAM when triggered.
module oam_dma_controller
  import gbc_mem_map_pkg::*;
#(
  parameter int unsigned P_READ_LATENCY = 2
) (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic [15:0] I_CPU_ADDR,
  input  logic [7:0]  I_CPU_DATA,
  output logic [7:0]  O_CPU_DATA,
  input  logic        I_CPU_WE_L,
  input  logic        I_CPU_RE_L,
  output logic [15:0] O_MEM_ADDR,
  inout  wire  [7:0]  IO_MEM_DATA,
  output logic        O_MEM_WE_L,
  output logic        O_MEM_RE_L,
  output logic        O_DMA_ACTIVE,
  output logic        O_DMA_DONE
);

  localparam logic [7:0] OAM_LAST = 8'(OAM_LEN - 1);
  localparam logic [2:0] LAT_LAST = 3'(P_READ_LATENCY - 1);

  dma_state_e r_state, w_state_next;
  logic [7:0]  r_dma_reg, r_idx, r_byte_buf;
  logic [2:0]  r_lat;
  logic        r_we_l_prev, r_active, r_done;
  logic        w_dma_wr, w_lat_last, w_busy;
  logic [15:0] w_src, w_dma_addr, w_mem_addr;
  logic        w_dma_we_l, w_dma_re_l;
  logic [7:0]  w_mem_dout;
  logic        w_mem_oe;

  // One capture per strobe: only the first low cycle of I_CPU_WE_L counts.
  assign w_dma_wr   = r_we_l_prev & ~I_CPU_WE_L & (I_CPU_ADDR == ADDR_DMA_REG);
  assign w_lat_last = (r_lat == LAT_LAST);
  assign w_busy     = (r_state != StIdle);
  assign w_src      = dma_src_base(r_dma_reg);

  // State register.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a 0xFF46 write always (re)starts the transfer.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_dma_wr) w_state_next = StStart;
      StStart: w_state_next = StRead;
      StRead:  if (w_lat_last) w_state_next = StWrite;
      StWrite: w_state_next = (r_idx == OAM_LAST) ? StIdle : StRead;
    endcase
    if (w_dma_wr) begin
      w_state_next = StStart;
    end
  end

  // DMA bus drive per state; a restart in WRITE suppresses the pending write.
  always_comb begin
    w_dma_addr = OAM_BASE;
    w_dma_we_l = 1'b1;
    w_dma_re_l = 1'b1;
    unique case (r_state)
      StRead: begin
        w_dma_addr = w_src + {8'h00, r_idx};
        w_dma_re_l = 1'b0;
      end
      StWrite: begin
        w_dma_addr = OAM_BASE + {8'h00, r_idx};
        w_dma_we_l = w_dma_wr;
      end
      default: ;
    endcase
  end

  // Datapath: DMA register, byte index, read latency counter, status flags.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      r_dma_reg   <= 8'h00;
      r_idx       <= 8'h00;
      r_byte_buf  <= 8'h00;
      r_lat       <= 3'd0;
      r_we_l_prev <= 1'b1;
      r_active    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_we_l_prev <= I_CPU_WE_L;
      r_active    <= (w_state_next != StIdle);
      r_done      <= (r_state == StWrite) && (r_idx == OAM_LAST) && !w_dma_wr;
      if (w_dma_wr) begin
        r_dma_reg <= I_CPU_DATA;
      end
      if (r_state == StStart) begin
        r_idx <= 8'h00;
        r_lat <= 3'd0;
      end else if (r_state == StRead) begin
        if (w_lat_last) begin
          r_byte_buf <= IO_MEM_DATA;
          r_lat      <= 3'd0;
        end else begin
          r_lat <= r_lat + 3'd1;
        end
      end else if (r_state == StWrite && r_idx != OAM_LAST) begin
        r_idx <= r_idx + 8'd1;
      end
    end
  end

  oam_dma_bus_mux u_bus_mux (
    .i_reset    (I_RESET),
    .i_busy     (w_busy),
    .i_cpu_addr (I_CPU_ADDR),
    .i_cpu_data (I_CPU_DATA),
    .i_cpu_we_l (I_CPU_WE_L),
    .i_cpu_re_l (I_CPU_RE_L),
    .i_dma_addr (w_dma_addr),
    .i_dma_data (r_byte_buf),
    .i_dma_we_l (w_dma_we_l),
    .i_dma_re_l (w_dma_re_l),
    .i_dma_reg  (r_dma_reg),
    .i_mem_data (IO_MEM_DATA),
    .o_mem_addr (w_mem_addr),
    .o_mem_data (w_mem_dout),
    .o_mem_oe   (w_mem_oe),
    .o_mem_we_l (O_MEM_WE_L),
    .o_mem_re_l (O_MEM_RE_L),
    .o_cpu_data (O_CPU_DATA)
  );

  assign O_MEM_ADDR   = w_mem_addr;
  assign IO_MEM_DATA  = w_mem_oe ? w_mem_dout : 8'hzz;
  assign O_DMA_ACTIVE = r_active;
  assign O_DMA_DONE   = r_done;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for oam_dma_controller with a behavioural 64 KiB memory on the bus.
module tb_oam_dma_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  wire  [7:0]  cpu_rdata;
  logic        cpu_we_l, cpu_re_l;
  wire  [15:0] mem_addr;
  wire  [7:0]  mem_bus;
  wire         mem_we_l, mem_re_l, dma_active, dma_done;

  int total = 0;
  int bad = 0;
  int oam_writes = 0;
  int stray_writes = 0;
  int done_cnt = 0;
  int both_low = 0;
  logic [7:0] mem [0:65535];

  always #5 clk = ~clk;

  oam_dma_controller #(.P_READ_LATENCY(2)) dut (
    .I_CLK        (clk),
    .I_RESET      (rst),
    .I_CPU_ADDR   (cpu_addr),
    .I_CPU_DATA   (cpu_wdata),
    .O_CPU_DATA   (cpu_rdata),
    .I_CPU_WE_L   (cpu_we_l),
    .I_CPU_RE_L   (cpu_re_l),
    .O_MEM_ADDR   (mem_addr),
    .IO_MEM_DATA  (mem_bus),
    .O_MEM_WE_L   (mem_we_l),
    .O_MEM_RE_L   (mem_re_l),
    .O_DMA_ACTIVE (dma_active),
    .O_DMA_DONE   (dma_done)
  );

  // Zero-latency memory: drives the bus on reads, stores on write strobes.
  assign mem_bus = (!mem_re_l && mem_we_l) ? mem[mem_addr] : 8'hzz;

  always @(posedge clk) begin
    if (!rst && !mem_we_l) begin
      mem[mem_addr] = mem_bus;
      if (mem_addr >= 16'hFE00 && mem_addr <= 16'hFE9F) oam_writes++;
      else stray_writes++;
    end
    if (dma_done) done_cnt++;
    if (!mem_we_l && !mem_re_l) both_low++;
  end

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_addr = a; cpu_wdata = d; cpu_we_l = 1'b0;
    @(negedge clk);
    cpu_we_l = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_addr = 16'hFF46; cpu_wdata = 8'h12; cpu_we_l = 1'b0; cpu_re_l = 1'b0;
    #2;
    total++;
    if (mem_we_l !== 1'b1 || mem_re_l !== 1'b1) begin
      bad++; $display("FAIL reset_strobes: got we=%b re=%b want 1 1", mem_we_l, mem_re_l);
    end
    total++;
    if (cpu_rdata !== 8'hFF) begin bad++; $display("FAIL reset_cpu_data: got %h want ff", cpu_rdata); end
    total++;
    if (dma_active !== 1'b0 || dma_done !== 1'b0) begin
      bad++; $display("FAIL reset_flags: got act=%b done=%b want 0 0", dma_active, dma_done);
    end
    cpu_we_l = 1'b1; cpu_re_l = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cpu_addr = 16'hFF46; cpu_re_l = 1'b0; #1;
    total++;
    if (cpu_rdata !== 8'h00) begin bad++; $display("FAIL reset_dma_reg: got %h want 00", cpu_rdata); end
    cpu_re_l = 1'b1;
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    cpu_addr = 16'hC010; cpu_wdata = 8'h5A; cpu_we_l = 1'b0; #1;
    total++;
    if (mem_addr !== 16'hC010 || mem_we_l !== 1'b0 || mem_re_l !== 1'b1 || mem_bus !== 8'h5A) begin
      bad++; $display("FAIL pass_write: got a=%h we=%b re=%b d=%h want c010 0 1 5a",
                      mem_addr, mem_we_l, mem_re_l, mem_bus);
    end
    @(negedge clk);
    cpu_we_l = 1'b1; cpu_re_l = 1'b0; #1;
    total++;
    if (mem_re_l !== 1'b0 || mem_we_l !== 1'b1 || cpu_rdata !== 8'h5A) begin
      bad++; $display("FAIL pass_read: got re=%b we=%b d=%h want 0 1 5a", mem_re_l, mem_we_l, cpu_rdata);
    end
    total++;
    if (dma_active !== 1'b0) begin bad++; $display("FAIL pass_active: got %b want 0", dma_active); end
    cpu_re_l = 1'b1;
  endtask

  task automatic test_full_transfer();
    int n;
    int errs;
    for (int i = 0; i < 160; i++) begin
      mem[16'hC000 + i] = 8'(i) ^ 8'hA5;
      mem[16'hFE00 + i] = 8'h00;
    end
    cpu_write(16'hFF46, 8'hC0);
    cpu_addr = 16'h0000; oam_writes = 0; stray_writes = 0; done_cnt = 0;
    total++;
    if (dma_active !== 1'b1) begin bad++; $display("FAIL full_active: got %b want 1", dma_active); end
    n = 0;
    while (dma_done !== 1'b1 && n < 600) begin
      @(negedge clk); n++;
      if (n == 1) begin
        total++;
        if (mem_addr !== 16'hC000 || mem_re_l !== 1'b0) begin
          bad++; $display("FAIL full_first_read: got a=%h re=%b want c000 0", mem_addr, mem_re_l);
        end
      end
      if (n == 3) begin
        total++;
        if (mem_addr !== 16'hFE00 || mem_we_l !== 1'b0 || mem_bus !== 8'hA5) begin
          bad++; $display("FAIL full_first_write: got a=%h we=%b d=%h want fe00 0 a5",
                          mem_addr, mem_we_l, mem_bus);
        end
      end
    end
    total++;
    if (n != 481) begin bad++; $display("FAIL full_done_time: got %0d want 481", n); end
    total++;
    if (dma_active !== 1'b0) begin bad++; $display("FAIL full_active_fall: got %b want 0", dma_active); end
    @(negedge clk);
    total++;
    if (dma_done !== 1'b0 || done_cnt != 1) begin
      bad++; $display("FAIL full_done_pulse: got done=%b cnt=%0d want 0 1", dma_done, done_cnt);
    end
    total++;
    if (oam_writes != 160 || stray_writes != 0) begin
      bad++; $display("FAIL full_write_count: got oam=%0d stray=%0d want 160 0", oam_writes, stray_writes);
    end
    errs = 0;
    for (int i = 0; i < 160; i++) if (mem[16'hFE00 + i] !== (8'(i) ^ 8'hA5)) errs++;
    total++;
    if (errs != 0) begin bad++; $display("FAIL full_oam_data: got %0d wrong bytes want 0", errs); end
    cpu_addr = 16'hFF46; cpu_re_l = 1'b0; #1;
    total++;
    if (cpu_rdata !== 8'hC0) begin bad++; $display("FAIL full_dma_reg: got %h want c0", cpu_rdata); end
    cpu_re_l = 1'b1;
  endtask

  task automatic test_blocking();
    int n;
    mem[16'hD000] = 8'h33;
    cpu_write(16'hFF46, 8'hC0);
    stray_writes = 0;
    repeat (10) @(negedge clk);
    cpu_addr = 16'hC000; cpu_re_l = 1'b0; #1;
    total++;
    if (cpu_rdata !== 8'hFF) begin bad++; $display("FAIL block_read: got %h want ff", cpu_rdata); end
    @(negedge clk);
    cpu_re_l = 1'b1; cpu_addr = 16'hD000; cpu_wdata = 8'h77; cpu_we_l = 1'b0; #1;
    total++;
    if (mem_addr === 16'hD000 && mem_we_l === 1'b0) begin
      bad++; $display("FAIL block_bus: got a=%h we=%b want no write to d000", mem_addr, mem_we_l);
    end
    @(negedge clk);
    cpu_we_l = 1'b1; cpu_addr = 16'h0000;
    n = 0;
    while (dma_done !== 1'b1 && n < 600) begin @(negedge clk); n++; end
    total++;
    if (stray_writes != 0 || mem[16'hD000] !== 8'h33) begin
      bad++; $display("FAIL block_write: got stray=%0d d000=%h want 0 33", stray_writes, mem[16'hD000]);
    end
  endtask

  task automatic test_echo_restart();
    int n;
    int errs;
    for (int i = 0; i < 160; i++) begin
      mem[16'hC100 + i] = 8'(i) ^ 8'h11;
      mem[16'hC200 + i] = 8'(i) ^ 8'h3C;
    end
    @(negedge clk);
    done_cnt = 0;
    cpu_write(16'hFF46, 8'hE1);
    cpu_addr = 16'h0000;
    @(negedge clk);
    total++;
    if (mem_addr !== 16'hC100 || mem_re_l !== 1'b0) begin
      bad++; $display("FAIL echo_src: got a=%h re=%b want c100 0", mem_addr, mem_re_l);
    end
    repeat (48) @(negedge clk);
    cpu_write(16'hFF46, 8'hC2);
    cpu_addr = 16'h0000;
    @(negedge clk);
    total++;
    if (mem_addr !== 16'hC200 || mem_re_l !== 1'b0) begin
      bad++; $display("FAIL restart_src: got a=%h re=%b want c200 0", mem_addr, mem_re_l);
    end
    n = 0;
    while (dma_done !== 1'b1 && n < 600) begin @(negedge clk); n++; end
    @(negedge clk);
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL restart_done_count: got %0d want 1", done_cnt); end
    errs = 0;
    for (int i = 0; i < 160; i++) if (mem[16'hFE00 + i] !== (8'(i) ^ 8'h3C)) errs++;
    total++;
    if (errs != 0) begin bad++; $display("FAIL restart_oam: got %0d wrong bytes want 0", errs); end
    cpu_addr = 16'hFF46; cpu_re_l = 1'b0; #1;
    total++;
    if (cpu_rdata !== 8'hC2) begin bad++; $display("FAIL restart_dma_reg: got %h want c2", cpu_rdata); end
    cpu_re_l = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n;
    int errs;
    for (int i = 0; i < 160; i++) begin
      mem[16'hC300 + i] = 8'(i) ^ 8'h5A;
      mem[16'hFE00 + i] = 8'h00;
    end
    cpu_write(16'hFF46, 8'hC3);
    cpu_addr = 16'h0000;
    n = 0;
    while (!(mem_addr === 16'hC350 && mem_re_l === 1'b0) && n < 600) begin @(negedge clk); n++; end
    rst = 1'b1; #1;
    total++;
    if (mem_we_l !== 1'b1 || mem_re_l !== 1'b1 || dma_active !== 1'b0) begin
      bad++; $display("FAIL midrst_outputs: got we=%b re=%b act=%b want 1 1 0",
                      mem_we_l, mem_re_l, dma_active);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    cpu_addr = 16'hFF46; cpu_re_l = 1'b0; #1;
    total++;
    if (cpu_rdata !== 8'h00 || dma_active !== 1'b0) begin
      bad++; $display("FAIL midrst_dma_reg: got reg=%h act=%b want 00 0", cpu_rdata, dma_active);
    end
    cpu_re_l = 1'b1;
    errs = 0;
    for (int i = 0; i < 80; i++) if (mem[16'hFE00 + i] !== (8'(i) ^ 8'h5A)) errs++;
    for (int i = 80; i < 160; i++) if (mem[16'hFE00 + i] !== 8'h00) errs++;
    total++;
    if (errs != 0) begin bad++; $display("FAIL midrst_oam: got %0d wrong bytes want 0", errs); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    test_reset();
    test_passthrough();
    test_full_transfer();
    test_blocking();
    test_echo_restart();
    test_reset_mid();
    total++;
    if (both_low != 0) begin bad++; $display("FAIL strobe_exclusive: got %0d cycles want 0", both_low); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
